// File: rtl/sensor_pingpong_buf.sv
// Two-bank ping-pong capture buffer: the sensor fills one bank while the core
// reads the other; full flags hand banks between writer and reader.
module sensor_pingpong_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sctrl_en,
  input  logic          sctrl_clear,
  input  logic [AW-1:0] sctrl_addr,
  input  logic          sensor_ready,
  input  logic [31:0]   sensor_out,
  output logic          sensor_en,
  output logic          sctrl_interrupt,
  output logic [31:0]   sctrl_out,
  output logic          overrun,
  output logic          rd_bank
);

  logic [1:0]    full_reg, full_next;
  logic          wbank_reg, wbank_next;
  logic          rbank_reg, rbank_next;
  logic [AW-1:0] wcnt_reg, wcnt_next;
  logic          overrun_reg, overrun_next;

  logic          wr_fire;
  logic          frame_end;
  logic          clear_fire;
  logic [31:0]   bank_rd [2];

  assign sensor_en  = sctrl_en & ~full_reg[wbank_reg] & ~rst;
  assign wr_fire    = sensor_en & sensor_ready;
  assign frame_end  = wr_fire & (wcnt_reg == AW'(DEPTH - 1));
  assign clear_fire = sctrl_clear & full_reg[rbank_reg];

  // Writer and reader never target the same bank when both fire, so the
  // set and clear of the two full flags below cannot collide.
  always_comb begin
    full_next    = full_reg;
    wbank_next   = wbank_reg;
    rbank_next   = rbank_reg;
    wcnt_next    = wcnt_reg;
    overrun_next = overrun_reg;
    if (wr_fire) begin
      wcnt_next = wcnt_reg + 1'b1;
    end
    if (frame_end) begin
      full_next[wbank_reg] = 1'b1;
      wbank_next           = ~wbank_reg;
      wcnt_next            = '0;
    end
    if (clear_fire) begin
      full_next[rbank_reg] = 1'b0;
      rbank_next           = ~rbank_reg;
      overrun_next         = 1'b0;
    end else if (sctrl_en && (&full_reg) && sensor_ready) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg    <= 2'b00;
      wbank_reg   <= 1'b0;
      rbank_reg   <= 1'b0;
      wcnt_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      full_reg    <= full_next;
      wbank_reg   <= wbank_next;
      rbank_reg   <= rbank_next;
      wcnt_reg    <= wcnt_next;
      overrun_reg <= overrun_next;
    end
  end

  // Banks are never cleared; reads are asynchronous so an address change is
  // visible in the same cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_fire && (wbank_reg == 1'(gi))) begin
        mem[wcnt_reg] <= sensor_out;
      end
    end

    assign bank_rd[gi] = mem[sctrl_addr];
  end

  assign sctrl_interrupt = full_reg[rbank_reg] & ~rst;
  assign sctrl_out       = sctrl_interrupt ? bank_rd[rbank_reg] : 32'h0;
  assign rd_bank         = rbank_reg & ~rst;
  assign overrun         = overrun_reg;

endmodule

// File: tb/tb_sensor_pingpong_buf.sv
// Directed bench for sensor_pingpong_buf: one task per scenario, each with
// hand-computed expectations.
module tb_sensor_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        sctrl_en;
  logic        sctrl_clear;
  logic [5:0]  sctrl_addr;
  logic        sensor_ready;
  logic [31:0] sensor_out;
  logic        sensor_en;
  logic        sctrl_interrupt;
  logic [31:0] sctrl_out;
  logic        overrun;
  logic        rd_bank;

  int checks = 0;
  int passes = 0;

  sensor_pingpong_buf #(.DEPTH(64), .AW(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sensor_ready    (sensor_ready),
    .sensor_out      (sensor_out),
    .sensor_en       (sensor_en),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_out       (sctrl_out),
    .overrun         (overrun),
    .rd_bank         (rd_bank)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      sctrl_en     = 1'b1;
      sensor_ready = 1'b1;
      sensor_out   = 32'(base + k);
      tick();
    end
    sensor_ready = 1'b0;
    #1;
  endtask

  task automatic do_clear();
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; sctrl_en = 1'b1; sctrl_clear = 1'b0; sctrl_addr = '0;
    sensor_ready = 1'b0; sensor_out = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sctrl_en = 1'b1; sctrl_clear = 1'b0; sctrl_addr = 6'd5;
    sensor_ready = 1'b1; sensor_out = 32'hdead;
    tick(); tick();
    checks++; if (sensor_en !== 1'b0) $display("FAIL reset_sensor_en got %b want 0", sensor_en); else passes++;
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL reset_interrupt got %b want 0", sctrl_interrupt); else passes++;
    checks++; if (sctrl_out !== 32'h0) $display("FAIL reset_sctrl_out got %h want 0", sctrl_out); else passes++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL reset_rd_bank got %b want 0", rd_bank); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passes++;
    rst = 1'b0; sensor_ready = 1'b0;
    #1;
    checks++; if (sensor_en !== 1'b1) $display("FAIL post_reset_sensor_en got %b want 1", sensor_en); else passes++;
  endtask

  task automatic test_fill();
    apply_reset();
    write_n(63, 0);
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL fill_63_interrupt got %b want 0", sctrl_interrupt); else passes++;
    checks++; if (sctrl_out !== 32'h0) $display("FAIL fill_63_out_hidden got %h want 0", sctrl_out); else passes++;
    write_n(1, 63);
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL fill_64_interrupt got %b want 1", sctrl_interrupt); else passes++;
    sctrl_addr = 6'd5; #1;
    checks++; if (sctrl_out !== 32'd5) $display("FAIL fill_addr5 got %0d want 5", sctrl_out); else passes++;
    sctrl_addr = 6'd0; #1;
    checks++; if (sctrl_out !== 32'd0) $display("FAIL fill_addr0 got %0d want 0", sctrl_out); else passes++;
    sctrl_addr = 6'd63; #1;
    checks++; if (sctrl_out !== 32'd63) $display("FAIL fill_addr63 got %0d want 63", sctrl_out); else passes++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL fill_rd_bank got %b want 0", rd_bank); else passes++;
    checks++; if (sensor_en !== 1'b1) $display("FAIL fill_bank1_open got %b want 1", sensor_en); else passes++;
  endtask

  // Continues from test_fill: bank 0 full, bank 1 empty.
  task automatic test_pingpong_overrun();
    write_n(64, 100);
    checks++; if (sensor_en !== 1'b0) $display("FAIL pp_both_full_sensor_en got %b want 0", sensor_en); else passes++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL pp_rd_bank_before got %b want 0", rd_bank); else passes++;
    write_n(3, 900);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else passes++;
    sctrl_addr = 6'd5; #1;
    checks++; if (sctrl_out !== 32'd5) $display("FAIL ovr_bank0_intact got %0d want 5", sctrl_out); else passes++;
    do_clear();
    checks++; if (rd_bank !== 1'b1) $display("FAIL pp_rd_bank_after got %b want 1", rd_bank); else passes++;
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL pp_interrupt_after got %b want 1", sctrl_interrupt); else passes++;
    checks++; if (sensor_en !== 1'b1) $display("FAIL pp_sensor_en_reopen got %b want 1", sensor_en); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_cleared got %b want 0", overrun); else passes++;
    sctrl_addr = 6'd3; #1;
    checks++; if (sctrl_out !== 32'd103) $display("FAIL pp_addr3 got %0d want 103", sctrl_out); else passes++;
    // Bank 0 refills from index 0: the overrun did not advance the counter.
    write_n(63, 500);
    do_clear();
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL ovr_wcnt_63_interrupt got %b want 0", sctrl_interrupt); else passes++;
    write_n(1, 563);
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL ovr_wcnt_64_interrupt got %b want 1", sctrl_interrupt); else passes++;
    sctrl_addr = 6'd0; #1;
    checks++; if (sctrl_out !== 32'd500) $display("FAIL ovr_refill_addr0 got %0d want 500", sctrl_out); else passes++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    write_n(64, 300);
    write_n(63, 400);
    sctrl_clear = 1'b1; sctrl_en = 1'b1; sensor_ready = 1'b1; sensor_out = 32'd463;
    tick();
    sctrl_clear = 1'b0; sensor_ready = 1'b0; sctrl_addr = 6'd63;
    #1;
    checks++; if (rd_bank !== 1'b1) $display("FAIL sim_rd_bank got %b want 1", rd_bank); else passes++;
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL sim_interrupt got %b want 1", sctrl_interrupt); else passes++;
    checks++; if (sctrl_out !== 32'd463) $display("FAIL sim_addr63 got %0d want 463", sctrl_out); else passes++;
    checks++; if (sensor_en !== 1'b1) $display("FAIL sim_sensor_en got %b want 1", sensor_en); else passes++;
  endtask

  task automatic test_stray_clear();
    apply_reset();
    write_n(10, 0);
    do_clear();
    checks++; if (rd_bank !== 1'b0) $display("FAIL stray_rd_bank got %b want 0", rd_bank); else passes++;
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL stray_interrupt got %b want 0", sctrl_interrupt); else passes++;
    write_n(53, 10);
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL stray_63_interrupt got %b want 0", sctrl_interrupt); else passes++;
    write_n(1, 63);
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL stray_64_interrupt got %b want 1", sctrl_interrupt); else passes++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL stray_final_rd_bank got %b want 0", rd_bank); else passes++;
  endtask

  task automatic test_gating();
    apply_reset();
    write_n(20, 600);
    sctrl_en = 1'b0; sensor_ready = 1'b1; sensor_out = 32'hbad0bad0;
    #1;
    checks++; if (sensor_en !== 1'b0) $display("FAIL gate_sensor_en got %b want 0", sensor_en); else passes++;
    for (int k = 0; k < 10; k++) tick();
    sensor_ready = 1'b0; sctrl_en = 1'b1;
    #1;
    checks++; if (rd_bank !== 1'b0) $display("FAIL gate_rd_bank got %b want 0", rd_bank); else passes++;
    write_n(43, 620);
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL gate_63_interrupt got %b want 0", sctrl_interrupt); else passes++;
    write_n(1, 663);
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL gate_64_interrupt got %b want 1", sctrl_interrupt); else passes++;
    sctrl_addr = 6'd19; #1;
    checks++; if (sctrl_out !== 32'd619) $display("FAIL gate_addr19 got %0d want 619", sctrl_out); else passes++;
    sctrl_addr = 6'd20; #1;
    checks++; if (sctrl_out !== 32'd620) $display("FAIL gate_addr20 got %0d want 620", sctrl_out); else passes++;
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    write_n(64, 700);
    write_n(20, 750);
    rst = 1'b1; sctrl_en = 1'b1; sctrl_addr = 6'd1;
    tick();
    checks++; if (sensor_en !== 1'b0) $display("FAIL rstmid_sensor_en got %b want 0", sensor_en); else passes++;
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL rstmid_interrupt got %b want 0", sctrl_interrupt); else passes++;
    checks++; if (sctrl_out !== 32'h0) $display("FAIL rstmid_out got %h want 0", sctrl_out); else passes++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL rstmid_rd_bank got %b want 0", rd_bank); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL rstmid_after_interrupt got %b want 0", sctrl_interrupt); else passes++;
    write_n(63, 800);
    checks++; if (sctrl_interrupt !== 1'b0) $display("FAIL rstmid_63_interrupt got %b want 0", sctrl_interrupt); else passes++;
    write_n(1, 863);
    checks++; if (sctrl_interrupt !== 1'b1) $display("FAIL rstmid_64_interrupt got %b want 1", sctrl_interrupt); else passes++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL rstmid_final_rd_bank got %b want 0", rd_bank); else passes++;
    sctrl_addr = 6'd0; #1;
    checks++; if (sctrl_out !== 32'd800) $display("FAIL rstmid_addr0 got %0d want 800", sctrl_out); else passes++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pingpong_overrun();
    test_simultaneous();
    test_stray_clear();
    test_gating();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sensor_pingpong_buf.md
SENSOR_PINGPONG_BUF -- requirements
Module: sensor_pingpong_buf

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter: DEPTH, default 64, words per bank (power of two).
REQ-003 Parameter: AW, default 6, bank address width, equal to log2(DEPTH).
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sctrl_en  input  1  core permits sampling.
REQ-007 sctrl_clear  input  1  core has finished copying the read bank; release it.
REQ-008 sctrl_addr  input  AW  word index within the read bank.
REQ-009 sensor_ready  input  1  sensor_out is valid this cycle.
REQ-010 sensor_out  input  32  sensor sample.
REQ-011 sensor_en  output  1  request samples from the sensor.
REQ-012 sctrl_interrupt  output  1  read bank holds a complete frame.
REQ-013 sctrl_out  output  32  sample at sctrl_addr in the read bank.
REQ-014 overrun  output  1  sticky flag: a sample was offered while both banks were full.
REQ-015 rd_bank  output  1  index of the bank currently presented to the core.

Function
REQ-016 State: two DEPTH x 32 banks; per-bank full[1:0]; write pointer wbank; read pointer rbank; write counter wcnt (AW bits); overrun.
REQ-017 Per-bank states: EMPTY (full=0, not wbank); FILLING (full=0, is wbank); FULL (full=1).
REQ-018 sensor_en SHALL be combinational: sctrl_en & ~full[wbank] & ~rst.
REQ-019 Write: when sensor_en & sensor_ready, store sensor_out at bank[wbank][wcnt] and increment wcnt.
REQ-020 Frame end: on a write with wcnt==DEPTH-1, set full[wbank], wrap wcnt to 0, and toggle wbank, all on the same edge.
REQ-021 sctrl_en low SHALL hold wcnt, wbank and bank contents, and SHALL ignore sensor_ready.
REQ-022 sctrl_interrupt SHALL be combinational: full[rbank].
REQ-023 sctrl_out SHALL be combinational: bank[rbank][sctrl_addr] when full[rbank]=1, and 32'h0 otherwise.
REQ-024 Read is zero-latency: a sctrl_addr change is visible on sctrl_out in the same cycle.
REQ-025 Clear: sctrl_clear & full[rbank] clears full[rbank] and toggles rbank; interrupt deasserts on the next cycle unless the other bank is already full.
REQ-026 sctrl_clear while full[rbank]=0 SHALL be ignored.
REQ-027 Clear of rbank and frame end on the other bank in the same cycle: both take effect; the new rbank is full, so interrupt stays high.
REQ-028 Both banks full: sensor_en=0, so no sample is written and wcnt holds.
REQ-029 In that case, sensor_ready=1 sets overrun.
REQ-030 overrun SHALL clear only on an accepted clear or on rst.
REQ-031 After a clear frees a bank while both are full, sensor_en SHALL reassert in the following cycle, given sctrl_en=1.
REQ-032 Bank contents are never cleared; only the full flags gate visibility.

Reset
REQ-033 While rst=1: full=2'b00, wbank=0, rbank=0, wcnt=0, overrun=0.
REQ-034 While rst=1, the outputs SHALL be: sensor_en=0, sctrl_interrupt=0, sctrl_out=0, rd_bank=0.
REQ-035 rst asserted mid-frame SHALL discard the partial frame and both full frames; filling restarts at bank 0, word 0.
REQ-036 No memory initialisation is required on reset.

Verification
REQ-037 Fill: sctrl_en=1, sensor_ready=1 for 64 cycles with sensor_out=i -> interrupt rises after the 64th write; sctrl_addr=5 gives sctrl_out=5; rd_bank=0; writes continue into bank 1.
REQ-038 Ping-pong: fill bank 0, then 64 more samples (100+i) with no clear -> sensor_en=0; clear -> rd_bank=1, interrupt stays 1, sctrl_addr=3 gives 103, sensor_en=1 next cycle.
REQ-039 Overrun: both banks full, sensor_ready=1 for 3 cycles -> overrun=1, wcnt unchanged; clear -> overrun=0.
REQ-040 Simultaneous events: clear in the same cycle as bank 1's 64th write -> rd_bank=1, interrupt=1 without a gap.
REQ-041 Stray clear: sctrl_clear with interrupt=0 -> no state change.
REQ-042 Gating: sctrl_en=0 for 10 cycles mid-frame -> wcnt and rd_bank unchanged.
REQ-043 Reset: rst after 20 writes -> all outputs at reset values; the next frame starts at bank 0, index 0.
